rvc_fetch_aligner: RTL and testbench



---
 rtl/rvc_fetch_aligner.sv | 230 +++++++++++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: buffers 32-bit fetch words as 16-bit parcels, reassembles mixed
// 16/32-bit streams and expands RV32C parcels to their RV32I equivalents.
module rvc_fetch_aligner #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          C_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed,
  output logic        out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW:0]   DEPTH_W   = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - 2);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [15:0]   q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   pc;
  logic          skip;

  logic [15:0] head_parcel, second_parcel;
  logic        need2, push_en, pop_en;
  logic [1:0]  push_n, pop_n, need_n;
  logic [32:0] xp;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW - 1){1'b0}}, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  // Returns {illegal, instr}; illegal parcels come back as {16'h0, parcel}.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, nz16, so;
    logic [9:0]  nzuimm;
    logic [6:0]  uimm7;
    logic [7:0]  uimm8;
    logic [20:0] ji;
    logic [12:0] bi;
    r      = 32'h0;
    ill    = 1'b0;
    rd     = c[11:7];
    rs2    = c[6:2];
    rdp    = {2'b01, c[4:2]};
    rs1p   = {2'b01, c[9:7]};
    imm6   = {{6{c[12]}}, c[12], c[6:2]};
    nzuimm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    uimm7  = {c[5], c[12:10], c[6], 2'b00};
    nz16   = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    ji     = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    bi     = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    uimm8  = 8'h0;
    so     = 12'h0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            ill = (nzuimm == 10'd0);
            r   = {2'b00, nzuimm, 5'd2, 3'b000, rdp, OP_IMM};
          end
          3'b010: r = {5'b0, uimm7, rs1p, 3'b010, rdp, OP_LD};
          3'b110: begin
            so = {5'b0, uimm7};
            r  = {so[11:5], rdp, rs1p, 3'b010, so[4:0], OP_ST};
          end
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: r = {imm6, rd, 3'b000, rd, OP_IMM};
          3'b001: r = {ji[20], ji[10:1], ji[11], ji[19:12], 5'd1, OP_JAL};
          3'b010: r = {imm6, 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            ill = ({c[12], c[6:2]} == 6'd0);
            if (rd == 5'd2) r = {nz16, 5'd2, 3'b000, 5'd2, OP_IMM};
            else            r = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI};
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin ill = c[12]; r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM}; end
              2'b01: begin ill = c[12]; r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM}; end
              2'b10: r = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                // c[12]=1 selects the RV64-only SUBW/ADDW group
                ill = c[12];
                case (c[6:5])
                  2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                  2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                  2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                  default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                endcase
              end
            endcase
          end
          3'b101: r = {ji[20], ji[10:1], ji[11], ji[19:12], 5'd0, OP_JAL};
          3'b110: r = {bi[12], bi[10:5], 5'd0, rs1p, 3'b000, bi[4:1], bi[11], OP_BR};
          default: r = {bi[12], bi[10:5], 5'd0, rs1p, 3'b001, bi[4:1], bi[11], OP_BR};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin ill = c[12]; r = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM}; end
          3'b010: begin
            uimm8 = {c[3:2], c[12], c[6:4], 2'b00};
            ill   = (rd == 5'd0);
            r     = {4'b0, uimm8, 5'd2, 3'b010, rd, OP_LD};
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin ill = (rd == 5'd0); r = {12'h0, rd, 3'b000, 5'd0, OP_JR}; end
              else r = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
            end else begin
              if (rs2 == 5'd0 && rd == 5'd0) r = 32'h0010_0073;
              else if (rs2 == 5'd0)          r = {12'h0, rd, 3'b000, 5'd1, OP_JR};
              else                           r = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
            end
          end
          3'b110: begin
            uimm8 = {c[8:7], c[12:9], 2'b00};
            so    = {4'b0, uimm8};
            r     = {so[11:5], rs2, 5'd2, 3'b010, so[4:0], OP_ST};
          end
          default: ill = 1'b1;
        endcase
      end
      default: r = 32'h0;
    endcase
    if (ill) r = {16'h0, c};
    return {ill, r};
  endfunction

  assign head_parcel   = q[head];
  assign second_parcel = q[wrap_add(head, 2'd1)];
  assign need2  = !(C_EN && head_parcel[1:0] != 2'b11);
  assign need_n = need2 ? 2'd2 : 2'd1;

  assign fetch_ready = rst_n && (count <= READY_LIM) && !flush;
  assign out_valid   = (count >= {{(CW - 2){1'b0}}, need_n}) && !flush;
  assign push_en     = fetch_valid && fetch_ready;
  assign pop_en      = out_valid && out_ready;
  assign push_n      = push_en ? (skip ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n       = pop_en ? need_n : 2'd0;
  assign count_nxt   = count + {{(CW - 2){1'b0}}, push_n} - {{(CW - 2){1'b0}}, pop_n};
  assign xp          = expand(head_parcel);

  always_comb begin
    out_instr      = 32'h0;
    out_compressed = 1'b0;
    out_illegal    = 1'b0;
    out_pc         = pc;
    if (out_valid) begin
      if (!need2) begin
        out_instr      = xp[31:0];
        out_illegal    = xp[32];
        out_compressed = 1'b1;
      end else if (head_parcel[1:0] == 2'b11) begin
        out_instr = {second_parcel, head_parcel};
      end else begin
        out_instr   = {16'h0, head_parcel};
        out_illegal = 1'b1;
      end
    end
  end

  // Parcel storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (skip) begin
        q[tail] <= fetch_data[31:16];
      end else begin
        q[tail]                  <= fetch_data[15:0];
        q[wrap_add(tail, 2'd1)]  <= fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= RESET_PC;
      skip  <= RESET_PC[1];
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= redirect_pc & 32'hFFFF_FFFE;
      skip  <= redirect_pc[1];
    end else begin
      if (push_en) begin
        tail <= wrap_add(tail, push_n);
        skip <= 1'b0;
      end
      if (pop_en) begin
        head <= wrap_add(head, pop_n);
        pc   <= pc + (need2 ? 32'd4 : 32'd2);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: one RV32C instance, one with C_EN=0.
module tb_rvc_fetch_aligner;
  logic        clk, rst_n;
  logic        flush, fv, ordy;
  logic [31:0] rpc, fd;
  logic        frdy, ovld, ocmp, oill;
  logic [31:0] oins, opc;
  logic        flush2, fv2, ordy2;
  logic [31:0] rpc2, fd2;
  logic        frdy2, ovld2, ocmp2, oill2;
  logic [31:0] oins2, opc2;
  int checks, errors;

  rvc_fetch_aligner #(.DEPTH(8), .RESET_PC(32'h0), .C_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .redirect_pc(rpc),
    .fetch_valid(fv), .fetch_data(fd), .fetch_ready(frdy),
    .out_valid(ovld), .out_ready(ordy), .out_instr(oins), .out_pc(opc),
    .out_compressed(ocmp), .out_illegal(oill));

  rvc_fetch_aligner #(.DEPTH(8), .RESET_PC(32'h0), .C_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .redirect_pc(rpc2),
    .fetch_valid(fv2), .fetch_data(fd2), .fetch_ready(frdy2),
    .out_valid(ovld2), .out_ready(ordy2), .out_instr(oins2), .out_pc(opc2),
    .out_compressed(ocmp2), .out_illegal(oill2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pcv, input logic cmp, input logic ill);
    check({tag, ".valid"}, 32'(ovld), 32'(v));
    check({tag, ".instr"}, oins, ins);
    check({tag, ".pc"}, opc, pcv);
    check({tag, ".comp"}, 32'(ocmp), 32'(cmp));
    check({tag, ".ill"}, 32'(oill), 32'(ill));
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; fv = 1'b0; ordy = 1'b0; rpc = 32'h0; fd = 32'h0;
    flush2 = 1'b0; fv2 = 1'b0; ordy2 = 1'b0; rpc2 = 32'h0; fd2 = 32'h0;
    #3;
    check("rst.fetch_ready", 32'(frdy), 32'd0);
    out_chk("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rel.fetch_ready", 32'(frdy), 32'd1);

    // C_EN=0: compressed encoding is illegal and consumes two parcels
    fv2 = 1'b1; fd2 = 32'h4505_4501;
    step();
    fv2 = 1'b0;
    check("nc.valid", 32'(ovld2), 32'd1);
    check("nc.ill", 32'(oill2), 32'd1);
    check("nc.instr", oins2, 32'h0000_4501);
    check("nc.pc", opc2, 32'h0);
    check("nc.comp", 32'(ocmp2), 32'd0);
    ordy2 = 1'b1;
    step();
    ordy2 = 1'b0;
    check("nc.after.valid", 32'(ovld2), 32'd0);
    check("nc.after.pc", opc2, 32'h4);

    // Two compressed parcels
    fv = 1'b1; fd = 32'h4505_4501;
    step();
    fv = 1'b0;
    out_chk("t1.a", 1'b1, 32'h0000_0513, 32'h0, 1'b1, 1'b0);
    ordy = 1'b1;
    step();
    out_chk("t1.b", 1'b1, 32'h0010_0513, 32'h2, 1'b1, 1'b0);
    step();
    out_chk("t1.empty", 1'b0, 32'h0, 32'h4, 1'b0, 1'b0);
    ordy = 1'b0;
    flush = 1'b1; rpc = 32'h0;
    step();
    flush = 1'b0;

    // Straddling 32-bit instruction
    fv = 1'b1; fd = 32'h0513_0001;
    step();
    fv = 1'b0;
    out_chk("t2.nop", 1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      out_chk("t2.wait", 1'b0, 32'h0, 32'h2, 1'b0, 1'b0);
    end
    fv = 1'b1; fd = 32'h0001_0000;
    step();
    fv = 1'b0;
    out_chk("t2.full", 1'b1, 32'h0000_0513, 32'h2, 1'b0, 1'b0);
    step();
    out_chk("t2.next", 1'b1, 32'h0000_0013, 32'h6, 1'b1, 1'b0);
    step();
    out_chk("t2.empty", 1'b0, 32'h0, 32'h8, 1'b0, 1'b0);

    // Odd-halfword redirect, with flush winning over a pending push
    ordy = 1'b0; fv = 1'b1; fd = 32'h4505_4501;
    step();
    flush = 1'b1; rpc = 32'h102;
    #1;
    check("t3.flush.valid", 32'(ovld), 32'd0);
    check("t3.flush.ready", 32'(frdy), 32'd0);
    step();
    flush = 1'b0; fv = 1'b0;
    #1 out_chk("t3.redir", 1'b0, 32'h0, 32'h102, 1'b0, 1'b0);
    fv = 1'b1; fd = 32'h4505_ABCD;
    step();
    fv = 1'b0;
    out_chk("t3.li", 1'b1, 32'h0010_0513, 32'h102, 1'b1, 1'b0);
    step();
    out_chk("t3.hold", 1'b1, 32'h0010_0513, 32'h102, 1'b1, 1'b0);
    ordy = 1'b1;
    step();
    out_chk("t3.empty", 1'b0, 32'h0, 32'h104, 1'b0, 1'b0);

    // Backpressure to full, then drain
    ordy = 1'b0; flush = 1'b1; rpc = 32'h0;
    step();
    flush = 1'b0; fv = 1'b1; fd = 32'h4505_4501;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("t4.fill%0d.ready", k), 32'(frdy), 32'(k <= 3));
    end
    fv = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      out_chk($sformatf("t4.drain%0d", k), 1'b1, (k % 2 == 0) ? 32'h0000_0513 : 32'h0010_0513,
              32'(2 * k), 1'b1, 1'b0);
      check($sformatf("t4.drain%0d.ready", k), 32'(frdy), 32'(k >= 2));
      step();
    end
    out_chk("t4.empty", 1'b0, 32'h0, 32'h10, 1'b0, 1'b0);

    // 32-bit instruction spanning the pointer wrap point
    ordy = 1'b0; flush = 1'b1; rpc = 32'h0;
    step();
    flush = 1'b0; fv = 1'b1; fd = 32'h0001_0001;
    repeat (3) step();
    fd = 32'h0513_0001;
    step();
    fv = 1'b0; ordy = 1'b1;
    repeat (7) step();
    out_chk("t4w.wait", 1'b0, 32'h0, 32'he, 1'b0, 1'b0);
    fv = 1'b1; fd = 32'h0001_0000;
    step();
    fv = 1'b0;
    out_chk("t4w.span", 1'b1, 32'h0000_0513, 32'he, 1'b0, 1'b0);
    step();
    out_chk("t4w.next", 1'b1, 32'h0000_0013, 32'h12, 1'b1, 1'b0);
    step();

    // Illegal and edge encodings
    ordy = 1'b0; fv = 1'b1; fd = 32'h6141_0000;
    step();
    fv = 1'b0;
    out_chk("t5.zero", 1'b1, 32'h0, 32'h14, 1'b1, 1'b1);
    ordy = 1'b1;
    step();
    out_chk("t5.addi16sp", 1'b1, 32'h0101_0113, 32'h16, 1'b1, 1'b0);
    step();
    out_chk("t5.empty", 1'b0, 32'h0, 32'h18, 1'b0, 1'b0);
    fv = 1'b1; fd = 32'h8002_8082;
    step();
    fv = 1'b0;
    out_chk("t5.ret", 1'b1, 32'h0000_8067, 32'h18, 1'b1, 1'b0);
    step();
    out_chk("t5.jr0", 1'b1, 32'h0000_8002, 32'h1a, 1'b1, 1'b1);
    step();
    out_chk("t5.end", 1'b0, 32'h0, 32'h1c, 1'b0, 1'b0);

    // Reset with five parcels queued
    ordy = 1'b0; fv = 1'b1; fd = 32'h4501_4501;
    repeat (3) step();
    fv = 1'b0; ordy = 1'b1;
    step();
    ordy = 1'b0;
    out_chk("t6.pre", 1'b1, 32'h0000_0513, 32'h1e, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    out_chk("t6.inrst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t6.inrst.ready", 32'(frdy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1 check("t6.rel.ready", 32'(frdy), 32'd1);
    out_chk("t6.rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    ordy = 1'b1;
    step();
    out_chk("t6.nostale", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
